// File: rtl/tx_fsrc_sample_en_seq.sv
// ---------------------------------------------------------------------------
// tx_fsrc_sample_en_seq
//
// Fractional sample-rate source for a TX path. NUM_SAMPLES lane accumulators
// advance by a common increment once per output beat. Each lane raises its
// sample-enable bit when its accumulator wraps. The wrap is either the
// natural carry out (WRAP_MODE=0) or a programmable modulus (WRAP_MODE=1).
// A small IDLE/RUN/DRAIN sequencer gates the advance and drains the last
// beat when the stream is stopped.
//
// Ports
//   clk          : rising-edge clock
//   resetn       : asynchronous active-low reset
//   set_val      : per-lane load value, loaded when set=1
//   set          : load set_val into every lane accumulator (any state)
//   add_val      : common increment added to every lane per advance
//   modulus      : wrap modulus (used only when WRAP_MODE=1)
//   start        : pulse, IDLE -> RUN (also clears overflow_cnt)
//   stop         : pulse, RUN -> DRAIN
//   out_ready    : downstream accepts the current beat
//   out_valid    : overflow holds a valid beat
//   overflow     : per-lane sample-enable vector, bit i = lane i
//   running      : high while in RUN or DRAIN
//   overflow_cnt : saturating count of accepted enable bits
//   dbg_state    : current sequencer state (00 IDLE, 01 RUN, 10 DRAIN)
//
// Handshake: a beat is transferred on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// beat, the accumulators and out_valid are frozen, so no beat is ever dropped
// or skipped. overflow is only meaningful while out_valid is high.
// ---------------------------------------------------------------------------
module tx_fsrc_sample_en_seq #(
  parameter int ACCUM_WIDTH = 64,
  parameter int NUM_SAMPLES = 8,
  parameter int WRAP_MODE   = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [NUM_SAMPLES-1:0][ACCUM_WIDTH-1:0] set_val,
  input  logic                                   set,
  input  logic [ACCUM_WIDTH-1:0]                 add_val,
  input  logic [ACCUM_WIDTH-1:0]                 modulus,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   out_ready,
  output logic                                   out_valid,
  output logic [NUM_SAMPLES-1:0]                 overflow,
  output logic                                   running,
  output logic [CNT_WIDTH-1:0]                   overflow_cnt,
  output logic [1:0]                             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                                 state_q, state_d;
  logic [NUM_SAMPLES-1:0][ACCUM_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_SAMPLES-1:0]                 overflow_q, overflow_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   running_q, running_d;
  logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;

  logic [NUM_SAMPLES-1:0][ACCUM_WIDTH-1:0] acc_nxt;
  logic [NUM_SAMPLES-1:0]                 ovf_vec;
  logic                                   beat_accept;
  logic                                   advance;
  logic                                   cnt_clear;
  logic [CNT_WIDTH:0]                     pop;
  logic [CNT_WIDTH:0]                     cnt_sum;

  // modulus only feeds the datapath in programmable-wrap mode
  logic unused_modulus;
  assign unused_modulus = ^modulus;

  // Per-lane next value and wrap flag, sum kept one bit wider than the lane.
  for (genvar g = 0; g < NUM_SAMPLES; g++) begin : g_lane
    logic [ACCUM_WIDTH:0] sum;
    assign sum = {1'b0, acc_q[g]} + {1'b0, add_val};
    if (WRAP_MODE == 0) begin : g_pow2
      assign ovf_vec[g] = sum[ACCUM_WIDTH];
      assign acc_nxt[g] = sum[ACCUM_WIDTH-1:0];
    end else begin : g_mod
      logic [ACCUM_WIDTH:0] diff;
      assign diff       = sum - {1'b0, modulus};
      assign ovf_vec[g] = (sum >= {1'b0, modulus});
      assign acc_nxt[g] = ovf_vec[g] ? diff[ACCUM_WIDTH-1:0] : sum[ACCUM_WIDTH-1:0];
    end
  end

  assign beat_accept = out_valid_q & out_ready;
  // stop and set both steal the cycle from the accumulators
  assign advance     = (state_q == ST_RUN) & ~stop & ~set & (~out_valid_q | out_ready);
  assign cnt_clear   = (state_q == ST_IDLE) & start & ~stop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      pop = pop + {{CNT_WIDTH{1'b0}}, overflow_q[i]};
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_RUN;
      ST_RUN:   if (stop) state_d = ST_DRAIN;
      ST_DRAIN: if (!out_valid_q || beat_accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    acc_d = acc_q;
    if (set) begin
      acc_d = set_val;
    end else if (advance) begin
      acc_d = acc_nxt;
    end

    overflow_d  = advance ? ovf_vec : overflow_q;

    // a new beat wins over retiring the old one; otherwise an accept empties
    out_valid_d = out_valid_q;
    if (advance) begin
      out_valid_d = 1'b1;
    end else if (beat_accept) begin
      out_valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (beat_accept) begin
      cnt_d = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
    end

    // registered from the next state so running tracks the state register
    running_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      overflow_q  <= '0;
      out_valid_q <= 1'b0;
      running_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      running_q   <= running_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign overflow     = overflow_q;
  assign running      = running_q;
  assign overflow_cnt = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/tx_fsrc_sample_en_seq.md
TX_FSRC_SAMPLE_EN_SEQ -- requirements
Module: tx_fsrc_sample_en_seq

Interface
REQ-001 Parameter ACCUM_WIDTH, 64, width of each lane accumulator and of add_val/set_val/modulus.
REQ-002 Parameter NUM_SAMPLES, 8, number of parallel lane accumulators, one per sample slot per clock.
REQ-003 Parameter WRAP_MODE, 0, 0 = power-of-two wrap (carry out); 1 = programmable-modulus wrap.
REQ-004 Parameter CNT_WIDTH, 32, width of overflow_cnt.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 set_val  in  [NUM_SAMPLES][ACCUM_WIDTH]  per-lane load value.
REQ-008 set  in  1  load set_val into all accumulators.
REQ-009 add_val  in  ACCUM_WIDTH  common increment.
REQ-010 modulus  in  ACCUM_WIDTH  wrap modulus; ignored when WRAP_MODE=0.
REQ-011 start  in  1  pulse; IDLE -> RUN.
REQ-012 stop  in  1  pulse; RUN -> DRAIN.
REQ-013 out_ready  in  1  downstream accepts current beat.
REQ-014 out_valid  out  1  overflow holds a valid beat.
REQ-015 overflow  out  NUM_SAMPLES  per-lane sample-enable vector; bit i = lane i.
REQ-016 running  out  1  high in RUN and DRAIN.
REQ-017 overflow_cnt  out  CNT_WIDTH  saturating count of accepted enable bits.

Function
REQ-018 Per lane, sum = acc + add_val computed at ACCUM_WIDTH+1 bits.
REQ-019 WRAP_MODE=0: ovf = sum[ACCUM_WIDTH], next = sum[ACCUM_WIDTH-1:0].
REQ-020 WRAP_MODE=1: ovf = (sum >= modulus), next = ovf ? sum - modulus : sum; values only defined for add_val < modulus and set_val < modulus.
REQ-021 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-022 IDLE: start=1 and stop=0 -> RUN, and overflow_cnt cleared to 0 that cycle; start and stop together -> stay IDLE.
REQ-023 Advance = state RUN and set=0 and (out_valid=0 or out_ready=1).
REQ-024 On advance: acc <= next, overflow <= ovf vector, out_valid <= 1 on the following edge (1-cycle latency from advance to beat).
REQ-025 out_valid=1 and out_ready=0: acc, overflow, out_valid held unchanged (no beat dropped or skipped).
REQ-026 out_valid=1, out_ready=1, no advance: out_valid <= 0.
REQ-027 Accepted beat (out_valid and out_ready): overflow_cnt += popcount(overflow), saturating at all-ones.
REQ-028 set=1 in any state: acc <= set_val, no advance that cycle; a simultaneous accepted beat still completes and out_valid <= 0.
REQ-029 RUN: stop=1 -> DRAIN, no advance that cycle; start ignored in RUN and DRAIN.
REQ-030 DRAIN: no advance; out_valid=0 or beat accepted -> IDLE.
REQ-031 overflow while out_valid=0 holds last value; consumers qualify with out_valid.
REQ-032 running = (state != IDLE), registered from state.

Reset
REQ-033 resetn low asynchronously forces: state IDLE, acc all 0, overflow 0, out_valid 0, running 0, overflow_cnt 0, without a clock edge.
REQ-034 Reset release synchronous to clk; first state change no earlier than first edge after deassertion.
REQ-035 Reset mid-beat discards the beat; no partial output after release.

Verification (ACCUM_WIDTH=8, NUM_SAMPLES=4, out_ready=1 unless stated)
REQ-036 WRAP_MODE=0, set_val={L0=0,L1=64,L2=128,L3=192}, add_val=64, set then start -> beats 4'b1000, 4'b0100, 4'b0010, 4'b0001, repeating; overflow_cnt=4 after 4 beats.
REQ-037 WRAP_MODE=1, modulus=100, set_val L0=0, L1=50, others 0, add_val=30 -> L0 enables on beat 4 (acc 30,60,90,20); L1 on beats 2 and 5 (acc 80,10,40,70,0).
REQ-038 Backpressure: out_ready low 3 cycles mid-run -> out_valid and overflow constant, next beat after release equals the unstalled next value.
REQ-039 stop during stall -> running stays 1, state DRAIN until beat accepted, then IDLE, out_valid 0, no further beats.
REQ-040 set during RUN with acc L0=200, add_val=64, set_val L0=10 -> no beat that cycle; next beat from acc 10 (L0 acc 74, ovf 0).
REQ-041 resetn low mid-run between edges -> out_valid, overflow, overflow_cnt, running 0 immediately; start after release resumes from acc 0.
